// File: rtl/voice_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : voice_sequencer                                             |
// | Purpose  : Per-sample voice sequencer and mixer. Walks NUM_VOICES       |
// |            voices through a shared generator, scales each raw wave by  |
// |            its envelope, sums with saturation and hands the sample to  |
// |            a valid/ready output.                                       |
// | Revision : 1.0 - initial parametrised release                          |
// +------------------------------------------------------------------------+
module voice_sequencer #(
  parameter  int NUM_VOICES = 3,
  parameter  int WAVE_W     = 10,
  parameter  int ENV_W      = 8,
  parameter  int OUT_W      = 16,
  parameter  int TIMEOUT    = 255,
  localparam int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        sample_tick_i,
  input  logic [NUM_VOICES*16-1:0]    freq_i,
  input  logic [NUM_VOICES*12-1:0]    pw_i,
  input  logic [NUM_VOICES*4-1:0]     wave_sel_i,
  input  logic [NUM_VOICES*ENV_W-1:0] env_i,
  input  logic                        voice_ready_i,
  input  logic [WAVE_W-1:0]           voice_wave_i,
  output logic                        voice_start_o,
  output logic [IDX_W-1:0]            voice_idx_o,
  output logic [15:0]                 voice_freq_o,
  output logic [11:0]                 voice_pw_o,
  output logic [3:0]                  voice_wave_o,
  output logic                        audio_valid_o,
  input  logic                        audio_ready_i,
  output logic [OUT_W-1:0]            audio_o,
  output logic                        overrun_o,
  output logic                        timeout_o
);

  // Accumulator carries enough headroom that summing every voice never wraps.
  localparam int ACC_W  = OUT_W + $clog2(NUM_VOICES) + 1;
  localparam int PROD_W = WAVE_W + ENV_W + 1;
  localparam int SHIFT  = OUT_W - WAVE_W - 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [WAVE_W:0]         WAVE_MID = {2'b01, {(WAVE_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t                   state, state_next;
  logic [IDX_W-1:0]         idx, idx_next;
  logic signed [ACC_W-1:0]  acc, acc_next;
  logic [CNT_W-1:0]         tcnt, tcnt_next;
  logic [OUT_W-1:0]         audio, audio_next;
  logic                     valid, valid_next;

  logic [15:0]              cur_freq;
  logic [11:0]              cur_pw;
  logic [3:0]               cur_sel;
  logic [ENV_W-1:0]         cur_env;

  logic signed [WAVE_W:0]   wave_s;
  logic signed [ENV_W:0]    env_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [WAVE_W:0]   scaled;
  logic signed [ACC_W-1:0]  scaled_ext;
  logic signed [ACC_W-1:0]  contrib;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     last_voice;
  logic                     timeout_hit;
  logic                     unused_prod_lsbs;

  function automatic logic [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[OUT_W-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[OUT_W-1:0];
    end
    return v[OUT_W-1:0];
  endfunction

  // Select the per-voice controls of the voice currently addressed by idx.
  always_comb begin
    cur_freq = '0;
    cur_pw   = '0;
    cur_sel  = '0;
    cur_env  = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (idx == IDX_W'(v)) begin
        cur_freq = freq_i[v*16 +: 16];
        cur_pw   = pw_i[v*12 +: 12];
        cur_sel  = wave_sel_i[v*4 +: 4];
        cur_env  = env_i[v*ENV_W +: ENV_W];
      end
    end
  end

  // Centre the raw wave, scale by envelope (floor divide by 2^ENV_W via the
  // arithmetic bit select) and align to the output sample's MSB range.
  assign wave_s           = $signed({1'b0, voice_wave_i} - WAVE_MID);
  assign env_s            = $signed({1'b0, cur_env});
  assign prod             = PROD_W'(wave_s) * PROD_W'(env_s);
  assign scaled           = $signed(prod[PROD_W-1:ENV_W]);
  assign unused_prod_lsbs = ^prod[ENV_W-1:0];
  assign scaled_ext       = ACC_W'(scaled);
  assign contrib          = scaled_ext <<< SHIFT;

  assign last_voice  = (idx == LAST_IDX);
  assign timeout_hit = (state == WAIT) && !voice_ready_i && (tcnt == CNT_LAST);
  assign acc_sum     = acc + (voice_ready_i ? contrib : '0);

  assign voice_start_o = (state == START) && (cur_sel != 4'd0);
  assign timeout_o     = timeout_hit;
  assign overrun_o     = sample_tick_i && (state != IDLE);
  assign voice_idx_o   = idx;
  assign voice_freq_o  = cur_freq;
  assign voice_pw_o    = cur_pw;
  assign voice_wave_o  = cur_sel;
  assign audio_o       = audio;
  assign audio_valid_o = valid;

  // Next-state and datapath update for the sequencing FSM.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    acc_next   = acc;
    tcnt_next  = tcnt;
    audio_next = audio;
    valid_next = valid;
    case (state)
      IDLE: begin
        if (sample_tick_i) begin
          acc_next   = '0;
          idx_next   = '0;
          state_next = START;
        end
      end
      START: begin
        if (cur_sel != 4'd0) begin
          tcnt_next  = '0;
          state_next = WAIT;
        end else if (last_voice) begin
          audio_next = saturate(acc);
          valid_next = 1'b1;
          state_next = OUTPUT;
        end else begin
          idx_next = idx + IDX_W'(1);
        end
      end
      WAIT: begin
        if (voice_ready_i || timeout_hit) begin
          acc_next = acc_sum;
          if (last_voice) begin
            audio_next = saturate(acc_sum);
            valid_next = 1'b1;
            state_next = OUTPUT;
          end else begin
            idx_next   = idx + IDX_W'(1);
            state_next = START;
          end
        end else begin
          tcnt_next = tcnt + CNT_W'(1);
        end
      end
      OUTPUT: begin
        if (valid && audio_ready_i) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any sample in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      idx   <= '0;
      acc   <= '0;
      tcnt  <= '0;
      audio <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      acc   <= acc_next;
      tcnt  <= tcnt_next;
      audio <= audio_next;
      valid <= valid_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_voice_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_voice_sequencer                                          |
// | Purpose  : Self-checking bench for voice_sequencer with a behavioural  |
// |            generator and mixing reference model.                       |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_voice_sequencer;

  localparam int NV      = 3;
  localparam int WAVE_W  = 10;
  localparam int ENV_W   = 8;
  localparam int OUT_W   = 16;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              sample_tick_i;
  logic [NV*16-1:0]  freq_i;
  logic [NV*12-1:0]  pw_i;
  logic [NV*4-1:0]   wave_sel_i;
  logic [NV*8-1:0]   env_i;
  logic              voice_ready_i;
  logic [9:0]        voice_wave_i;
  logic              voice_start_o;
  logic [1:0]        voice_idx_o;
  logic [15:0]       voice_freq_o;
  logic [11:0]       voice_pw_o;
  logic [3:0]        voice_wave_o;
  logic              audio_valid_o;
  logic              audio_ready_i;
  logic [15:0]       audio_o;
  logic              overrun_o;
  logic              timeout_o;

  voice_sequencer #(
    .NUM_VOICES (NV),
    .WAVE_W     (WAVE_W),
    .ENV_W      (ENV_W),
    .OUT_W      (OUT_W),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .sample_tick_i (sample_tick_i),
    .freq_i        (freq_i),
    .pw_i          (pw_i),
    .wave_sel_i    (wave_sel_i),
    .env_i         (env_i),
    .voice_ready_i (voice_ready_i),
    .voice_wave_i  (voice_wave_i),
    .voice_start_o (voice_start_o),
    .voice_idx_o   (voice_idx_o),
    .voice_freq_o  (voice_freq_o),
    .voice_pw_o    (voice_pw_o),
    .voice_wave_o  (voice_wave_o),
    .audio_valid_o (audio_valid_o),
    .audio_ready_i (audio_ready_i),
    .audio_o       (audio_o),
    .overrun_o     (overrun_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int cfg_sel[NV];
  int cfg_env[NV];
  int cfg_freq[NV];
  int cfg_pw[NV];
  int gen_lat[NV];   // WAIT cycles until ready; 0 = never ready
  int gen_wave[NV];

  int starts[$];
  int to_cnt;
  int ov_cnt;
  int xfer_cnt;

  int gen_busy;
  int gen_cnt;
  int gen_lat_cur;
  int gen_wave_cur;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: centred wave times envelope, floor-divided by 256, times 32.
  function automatic int ref_contrib(input int wave, input int env);
    int s;
    int p;
    int q;
    s = wave - (1 << (WAVE_W - 1));
    p = s * env;
    if (p >= 0) q = p / (1 << ENV_W);
    else        q = -((-p + (1 << ENV_W) - 1) / (1 << ENV_W));
    return q * (1 << (OUT_W - WAVE_W - 1));
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Generator model: answers each start pulse after the configured latency.
  initial begin
    voice_ready_i = 1'b0;
    voice_wave_i  = '0;
    gen_busy      = 0;
    forever begin
      @(negedge clk);
      #1;
      voice_ready_i = 1'b0;
      voice_wave_i  = 10'($urandom);
      if (rst_ni !== 1'b1) begin
        gen_busy = 0;
      end else begin
        if (gen_busy != 0) begin
          gen_cnt++;
          if (gen_cnt == gen_lat_cur) begin
            voice_ready_i = 1'b1;
            voice_wave_i  = 10'(gen_wave_cur);
            gen_busy      = 0;
          end
        end
        if (voice_start_o === 1'b1) begin
          gen_busy     = 1;
          gen_cnt      = 0;
          gen_lat_cur  = gen_lat[voice_idx_o];
          gen_wave_cur = gen_wave[voice_idx_o];
        end
      end
    end
  end

  // Event monitor: counts pulses and checks the per-voice control mux.
  initial begin
    to_cnt   = 0;
    ov_cnt   = 0;
    xfer_cnt = 0;
    forever begin
      @(negedge clk);
      #3;
      if (rst_ni === 1'b1) begin
        if (timeout_o === 1'b1) to_cnt++;
        if (overrun_o === 1'b1) ov_cnt++;
        if (audio_valid_o === 1'b1 && audio_ready_i === 1'b1) xfer_cnt++;
        if (voice_start_o === 1'b1) begin
          starts.push_back(int'(voice_idx_o));
          if (voice_idx_o < 2'(NV)) begin
            chk("mux_freq", 32'(voice_freq_o), cfg_freq[voice_idx_o]);
            chk("mux_pw",   32'(voice_pw_o),   cfg_pw[voice_idx_o]);
            chk("mux_wave", 32'(voice_wave_o), cfg_sel[voice_idx_o]);
          end
        end
      end
    end
  end

  task automatic apply_cfg();
    for (int v = 0; v < NV; v++) begin
      cfg_freq[v] = int'($urandom_range(0, 65535));
      cfg_pw[v]   = int'($urandom_range(0, 4095));
      wave_sel_i[v*4 +: 4] = 4'(cfg_sel[v]);
      env_i[v*8 +: 8]      = 8'(cfg_env[v]);
      freq_i[v*16 +: 16]   = 16'(cfg_freq[v]);
      pw_i[v*12 +: 12]     = 12'(cfg_pw[v]);
    end
  endtask

  function automatic int expected_audio();
    int sum;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      if (cfg_sel[v] != 0 && gen_lat[v] >= 1 && gen_lat[v] <= TIMEOUT)
        sum += ref_contrib(gen_wave[v], cfg_env[v]);
    end
    return clamp16(sum) & 32'hFFFF;
  endfunction

  task automatic wait_valid(input string tag, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      #4;
      if (audio_valid_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_valid"}, 32'(seen), 1);
  endtask

  // One full sample with the downstream always ready.
  task automatic run_sample(input string tag);
    int exp_starts[$];
    int exp_to;
    int n;
    bit seen;
    exp_to = 0;
    for (int v = 0; v < NV; v++) begin
      if (cfg_sel[v] != 0) begin
        exp_starts.push_back(v);
        if (gen_lat[v] < 1 || gen_lat[v] > TIMEOUT) exp_to++;
      end
    end
    audio_ready_i = 1'b1;
    apply_cfg();
    @(negedge clk);
    starts.delete();
    to_cnt = 0;
    sample_tick_i = 1'b1;
    @(negedge clk);
    sample_tick_i = 1'b0;
    wait_valid(tag, seen);
    chk({tag, "_audio"}, 32'(audio_o), expected_audio());
    chk({tag, "_nstarts"}, starts.size(), exp_starts.size());
    n = (starts.size() < exp_starts.size()) ? starts.size() : exp_starts.size();
    for (int i = 0; i < n; i++) chk({tag, "_start_idx"}, starts[i], exp_starts[i]);
    chk({tag, "_timeouts"}, to_cnt, exp_to);
    @(negedge clk);
    #4;
    chk({tag, "_valid_drop"}, 32'(audio_valid_o), 0);
  endtask

  task automatic set_voice(input int v, input int sel, input int env, input int wave, input int lat);
    cfg_sel[v]  = sel;
    cfg_env[v]  = env;
    gen_wave[v] = wave;
    gen_lat[v]  = lat;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int exp_a;
    rst_ni        = 1'b0;
    sample_tick_i = 1'b0;
    audio_ready_i = 1'b1;
    freq_i        = '0;
    pw_i          = '0;
    wave_sel_i    = '0;
    env_i         = '0;
    for (int v = 0; v < NV; v++) set_voice(v, 0, 0, 0, 1);

    // Reset state, before any clock edge.
    #2;
    chk("rst_audio", 32'(audio_o), 0);
    chk("rst_valid", 32'(audio_valid_o), 0);
    chk("rst_start", 32'(voice_start_o), 0);
    chk("rst_overrun", 32'(overrun_o), 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    chk("rst_idx", 32'(voice_idx_o), 0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    // All voices full scale: sum saturates positive.
    for (int v = 0; v < NV; v++) set_voice(v, 1, 255, 1023, v + 1);
    run_sample("full_pos");

    // Voice 0 only, minimum wave.
    set_voice(0, 1, 255, 0, 2);
    set_voice(1, 0, 255, 1023, 1);
    set_voice(2, 0, 255, 1023, 1);
    run_sample("v0_neg");

    // Cancelling voices, then voice 0 alone.
    set_voice(0, 2, 128, 768, 3);
    set_voice(1, 5, 128, 256, 1);
    set_voice(2, 9, 255, 512, 4);
    run_sample("cancel");
    cfg_sel[1] = 0;
    cfg_sel[2] = 0;
    run_sample("v0_alone");

    // Voice 1 never answers: abandoned on timeout, voice 2 still started.
    for (int v = 0; v < NV; v++) set_voice(v, 1, 255, 1023, 2);
    gen_lat[1] = 0;
    run_sample("timeout");
    // Ready arriving on exactly the last allowed WAIT cycle.
    gen_lat[1] = TIMEOUT;
    run_sample("ready_at_limit");

    // Backpressure with ticks dropped while the sample is held.
    set_voice(0, 3, 200, 900, 1);
    set_voice(1, 4, 100, 300, 2);
    set_voice(2, 6, 50, 600, 3);
    apply_cfg();
    audio_ready_i = 1'b0;
    @(negedge clk);
    sample_tick_i = 1'b1;
    @(negedge clk);
    sample_tick_i = 1'b0;
    wait_valid("bp", seen);
    exp_a = expected_audio();
    chk("bp_audio", 32'(audio_o), exp_a);
    ov_cnt   = 0;
    xfer_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sample_tick_i = (i == 2 || i == 6);
      #4;
      chk("bp_hold_valid", 32'(audio_valid_o), 1);
      chk("bp_hold_audio", 32'(audio_o), exp_a);
    end
    @(negedge clk);
    sample_tick_i = 1'b0;
    audio_ready_i = 1'b1;
    #4;
    chk("bp_overruns", ov_cnt, 2);
    @(negedge clk);
    #4;
    chk("bp_valid_drop", 32'(audio_valid_o), 0);
    chk("bp_transfers", xfer_cnt, 1);
    for (int v = 0; v < NV; v++) set_voice(v, 1, 180, 100 + 300 * v, 1);
    run_sample("bp_next");

    // Reset while waiting on the generator.
    set_voice(0, 1, 255, 1023, 0);
    apply_cfg();
    @(negedge clk);
    sample_tick_i = 1'b1;
    @(negedge clk);
    sample_tick_i = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_audio", 32'(audio_o), 0);
    chk("arst_valid", 32'(audio_valid_o), 0);
    chk("arst_start", 32'(voice_start_o), 0);
    chk("arst_timeout", 32'(timeout_o), 0);
    chk("arst_idx", 32'(voice_idx_o), 0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #4;
      if (audio_valid_o !== 1'b0) seen = 1'b1;
    end
    chk("arst_no_valid", 32'(seen), 0);
    for (int v = 0; v < NV; v++) set_voice(v, 1, 255, 1023, 1);
    run_sample("arst_recover");

    // Randomised samples against the reference model.
    for (int t = 0; t < 15; t++) begin
      for (int v = 0; v < NV; v++) begin
        set_voice(v,
                  ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15)),
                  int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1023)),
                  int'($urandom_range(1, 6)));
      end
      run_sample("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
